// File: rtl/hilo_mult_unit.sv
// Sequential unsigned shift-add multiplier (MULTU) that owns the Hi/Lo register pair.
// One iteration per clock; Hi/Lo update only when the 32nd iteration completes.
module hilo_mult_unit #(
  parameter int unsigned WIDTH = 32,
  parameter logic [5:0]  MULTU = 6'b011001
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [5:0]       Signal,
  input  logic             Start,
  output logic [WIDTH-1:0] HiOut,
  output logic [WIDTH-1:0] LoOut,
  output logic             Busy,
  output logic             Done
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] p_q, p_next;
  logic [WIDTH-1:0]   m_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH:0]     sum;
  logic               accept, last;

  assign accept = Start && (Signal == MULTU) && ((state_q == IDLE) || (state_q == DONE));
  assign last   = (state_q == RUN) && (cnt_q == CW'(WIDTH - 1));

  // Carry of the upper-half add is kept in sum[WIDTH] and shifted into P.
  always_comb begin
    sum    = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, m_q} : '0);
    p_next = {sum, p_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    Busy    = 1'b0;
    Done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) state_d = RUN;
      end
      RUN: begin
        Busy = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        Done    = 1'b1;
        state_d = accept ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_q   <= '0;
      m_q   <= '0;
      cnt_q <= '0;
      HiOut <= '0;
      LoOut <= '0;
    end else if (accept) begin
      p_q   <= {{WIDTH{1'b0}}, dataB};
      m_q   <= dataA;
      cnt_q <= '0;
    end else if (state_q == RUN) begin
      p_q   <= p_next;
      cnt_q <= cnt_q + CW'(1);
      if (last) begin
        HiOut <= p_next[2*WIDTH-1:WIDTH];
        LoOut <= p_next[WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_hilo_mult_unit.sv
// Randomized self-checking bench for hilo_mult_unit against a plain-arithmetic product model.
module tb_hilo_mult_unit;

  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] ADD   = 6'b100000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] dataA, dataB;
  logic [5:0]  Signal;
  logic        Start;
  logic [31:0] HiOut, LoOut;
  logic        Busy, Done;

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [63:0] hilo_exp;  // product the Hi/Lo pair should currently hold
  logic [63:0] pend;      // product of the operation in flight

  hilo_mult_unit #(.WIDTH(32), .MULTU(MULTU)) dut (
    .clk   (clk),
    .reset (reset),
    .dataA (dataA),
    .dataB (dataB),
    .Signal(Signal),
    .Start (Start),
    .HiOut (HiOut),
    .LoOut (LoOut),
    .Busy  (Busy),
    .Done  (Done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive a MULTU request; caller is at a negedge so it is sampled at the next posedge.
  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    Start  = 1'b1;
    Signal = MULTU;
    dataA  = a;
    dataB  = b;
    pend   = {32'b0, a} * {32'b0, b};
  endtask

  // Follows one operation from its accepting edge through the Done cycle.
  task automatic finish_op(input bit poke);
    @(posedge clk);
    #1;
    Start = 1'b0;
    dataA = $urandom;
    dataB = $urandom;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      chk("run_busy", {63'b0, Busy}, 64'd1);
      chk("run_done", {63'b0, Done}, 64'd0);
      chk("run_hilo", {HiOut, LoOut}, hilo_exp);
      if (poke && i == 4) begin
        Start  = 1'b1;
        Signal = MULTU;
        dataA  = 32'd2;
        dataB  = 32'd2;
      end
      if (poke && i == 5) Start = 1'b0;
    end
    @(negedge clk);
    hilo_exp = pend;
    chk("end_done", {63'b0, Done}, 64'd1);
    chk("end_busy", {63'b0, Busy}, 64'd0);
    chk("end_hilo", {HiOut, LoOut}, hilo_exp);
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    chk({tag, "_busy"}, {63'b0, Busy}, 64'd0);
    chk({tag, "_done"}, {63'b0, Done}, 64'd0);
    chk({tag, "_hilo"}, {HiOut, LoOut}, hilo_exp);
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input bit poke);
    launch(a, b);
    finish_op(poke);
    Start = 1'b0;
    check_idle("after");
  endtask

  initial begin
    reset    = 1'b0;
    Start    = 1'b0;
    Signal   = '0;
    dataA    = '0;
    dataB    = '0;
    hilo_exp = '0;
    pend     = '0;
    repeat (3) @(negedge clk);
    chk("rst_hilo", {HiOut, LoOut}, 64'd0);
    chk("rst_busy", {63'b0, Busy}, 64'd0);
    chk("rst_done", {63'b0, Done}, 64'd0);
    reset = 1'b1;
    @(negedge clk);

    do_op(32'd3, 32'd5, 1'b0);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    do_op(32'h8000_0000, 32'd2, 1'b0);

    // Non-MULTU function code must be ignored.
    Start  = 1'b1;
    Signal = ADD;
    dataA  = 32'd11;
    dataB  = 32'd13;
    @(negedge clk);
    Start = 1'b0;
    chk("add_busy", {63'b0, Busy}, 64'd0);
    chk("add_hilo", {HiOut, LoOut}, hilo_exp);
    check_idle("add");

    do_op(32'd7, 32'd9, 1'b1);
    chk("lo_3f", {32'b0, LoOut}, 64'h3F);

    // Reset mid-run clears everything asynchronously.
    launch(32'd123456, 32'd654321);
    @(posedge clk);
    #1;
    Start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b0;
    #1;
    hilo_exp = '0;
    chk("arst_hilo", {HiOut, LoOut}, 64'd0);
    chk("arst_busy", {63'b0, Busy}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    check_idle("post_rst");
    do_op(32'd6, 32'd7, 1'b0);

    // Back-to-back: new accept in the DONE cycle.
    launch(32'd1234, 32'd5678);
    finish_op(1'b0);
    launch(32'h0001_0000, 32'h0001_0000);
    finish_op(1'b0);
    Start = 1'b0;
    chk("b2b_hilo", {HiOut, LoOut}, 64'h0000_0001_0000_0000);
    check_idle("b2b");

    do_op(32'd0, $urandom, 1'b0);
    do_op($urandom, 32'd0, 1'b0);

    for (int n = 0; n < 10; n++) begin
      launch($urandom, $urandom);
      finish_op(($urandom_range(0, 1) == 1));
      if ($urandom_range(0, 1) == 1) begin
        launch($urandom, $urandom);
        finish_op(1'b0);
      end
      Start = 1'b0;
      check_idle("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
